// File: rtl/spi_slave_param.sv
// SPI slave (all CPOL/CPHA modes) with oversampled pins, a tx holding register
// and strobed rx words; several words may follow each other in one cs frame.
module spi_slave_param #(
  parameter int                 DATA_W      = 8,
  parameter bit                 CPOL        = 1'b0,
  parameter bit                 CPHA        = 1'b0,
  parameter bit                 LSB_FIRST   = 1'b1,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  TX_DEFAULT  = DATA_W'(8'h9E)
) (
  input  logic              seq_clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {WAIT_CS, IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      tx_shift;
  logic [DATA_W-1:0]      rx_shift;
  logic [DATA_W-1:0]      hold_data;
  logic                   hold_full;
  logic                   done_pend;

  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, lead, trail;
  logic sample_edge, shift_edge;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rx_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // cs resets to "selected" so a reset inside a frame waits for a real cs release
  always_ff @(posedge seq_clk) begin
    if (rst) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= CPOL;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign rise        = sclk_s & ~sclk_prev;
  assign fall        = ~sclk_s & sclk_prev;
  assign lead        = CPOL ? fall : rise;
  assign trail       = CPOL ? rise : fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;

  assign load_word = hold_full ? hold_data : TX_DEFAULT;
  assign rx_next   = LSB_FIRST ? {mosi_s, rx_shift[DATA_W-1:1]}
                               : {rx_shift[DATA_W-2:0], mosi_s};

  assign tx_ready = ~hold_full;
  assign busy     = (state == ACTIVE);
  assign miso_oe  = (state == ACTIVE);

  // miso holds the bit currently on the wire; tx_shift holds the bits still to go
  always_ff @(posedge seq_clk) begin
    if (rst) begin
      state       <= WAIT_CS;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      done_pend   <= 1'b0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      done_pend   <= 1'b0;

      if (done_pend) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end

      case (state)
        WAIT_CS: begin
          miso <= 1'b0;
          if (cs_s) state <= IDLE;
        end
        IDLE: begin
          bit_cnt <= '0;
          miso    <= 1'b0;
          if (!cs_s) begin
            state <= ACTIVE;
            if (hold_full) hold_full <= 1'b0;
            else           tx_underrun <= 1'b1;
            if (!CPHA) begin
              miso     <= first_bit(load_word);
              tx_shift <= shift_word(load_word);
            end else begin
              tx_shift <= load_word;
            end
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            if (bit_cnt != '0) frame_err <= 1'b1;
            bit_cnt <= '0;
            miso    <= 1'b0;
            state   <= IDLE;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              done_pend <= 1'b1;
              tx_shift  <= load_word;
              if (hold_full) hold_full <= 1'b0;
              else           tx_underrun <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (shift_edge) begin
            miso     <= first_bit(tx_shift);
            tx_shift <= shift_word(tx_shift);
          end
        end
        default: state <= WAIT_CS;
      endcase

      // placed last so a same-cycle accept overrides the consume of an empty register
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
